cr_huf_comp_mq: RTL and testbench

CR_HUF_COMP_MQ -- requirements
Module: cr_huf_comp_mq

---
 rtl/cr_huf_compPKG.sv | 33 +++
 rtl/cr_huf_comp_mq_chan.sv | 82 ++++++++
 rtl/cr_huf_comp_mq.sv | 86 ++++++++
 tb/tb_cr_huf_comp_mq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_compPKG.sv
// rtl/cr_huf_compPKG.sv - shared constants and types for the huffman compressor symbol queues
//
// Purpose: symbol-queue constants (entry layout, widths) and the multi-queue
//          defaults used by cr_huf_comp_mq, plus a small index-width helper.
// Ports:   none (package).
package cr_huf_compPKG;

  // Symbol-queue entry layout, packed MSB first.
  localparam int HUF_SYM_DATA_W   = 64;
  localparam int HUF_SYM_SEQ_W    = 4;
  localparam int HUF_SYM_BVLD_W   = 3;
  localparam int HUF_SYM_W        = 1 + 1 + HUF_SYM_BVLD_W + 1 + 1 + HUF_SYM_SEQ_W + HUF_SYM_DATA_W;

  typedef struct packed {
    logic                      eot;
    logic                      sot;
    logic [HUF_SYM_BVLD_W-1:0] byte_vld;
    logic                      tlast;
    logic                      eob;
    logic [HUF_SYM_SEQ_W-1:0]  seq_id;
    logic [HUF_SYM_DATA_W-1:0] data;
  } huf_sym_t;

  // Multi-queue defaults.
  localparam int N_HUFF_MQ_CH    = 2;
  localparam int N_HUFF_MQ_DEPTH = 16;

  // Width of a select bus addressing n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_huf_comp_mq_chan.sv
// rtl/cr_huf_comp_mq_chan.sv - single symbol-queue channel (circular buffer)
//
// Purpose: one first-word-fall-through circular buffer with occupancy counter,
//          almost-full ready guard and sticky overflow/underflow flags.
// Ports:   clk, rst_n (sync active-low), clr (sync flush)
//          wr/wdata   - write request already decoded for this channel
//          rd         - pop request already decoded for this channel
//          rdata      - head entry (valid while empty=0)
//          used, empty, aempty, full, rdy - status
//          overflow, underflow - sticky error flags
module cr_huf_comp_mq_chan #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 75,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int UW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [UW-1:0]    used,
  output logic             empty,
  output logic             aempty,
  output logic             full,
  output logic             rdy,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [UW-1:0] DEPTH_U  = UW'(DEPTH);
  localparam logic [UW-1:0] AFULL_U  = UW'(AFULL_LVL);
  localparam logic [UW-1:0] AEMPTY_U = UW'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty  = (used == '0);
  assign full   = (used == DEPTH_U);
  assign aempty = !empty && (used <= AEMPTY_U);

  // Below the guard level a write is always safe; above it, only an idle
  // non-full channel advertises ready so a producer cannot race into full.
  assign rdy = (used < AFULL_U) || (!full && !wr);

  // Acceptance is judged on the pre-edge state: a pop in the same cycle does
  // not make room for a write to a full channel, and a write to an empty
  // channel does not satisfy a same-cycle pop.
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr      <= '0;
      rptr      <= '0;
      used      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      used <= used + UW'(wr_ok) - UW'(rd_ok);
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

  // Storage carries no reset; flushed contents are simply unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && wr_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cr_huf_comp_mq.sv
// rtl/cr_huf_comp_mq.sv - multi-channel huffman symbol queue
//
// Purpose: N_CH independent symbol queues sharing one write port and one
//          pop port, addressed by wr_ch / rd_ch.
// Ports:   clk, rst_n (sync active-low)
//          wr, wr_ch, wdata  - write port; rdy is per-channel write-ready
//          rd, rd_ch, rdata  - pop port; rdata is the head of rd_ch (FWFT)
//          empty, aempty, full, used_slots - per-channel status
//          clr               - per-channel synchronous flush
//          overflow, underflow - per-channel sticky error flags
module cr_huf_comp_mq
  import cr_huf_compPKG::*;
#(
  parameter int N_CH       = N_HUFF_MQ_CH,
  parameter int DEPTH      = N_HUFF_MQ_DEPTH,
  parameter int WIDTH      = HUF_SYM_W,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr,
  input  logic [idx_w(N_CH)-1:0]             wr_ch,
  input  logic [WIDTH-1:0]                   wdata,
  output logic [N_CH-1:0]                    rdy,
  input  logic                               rd,
  input  logic [idx_w(N_CH)-1:0]             rd_ch,
  output logic [WIDTH-1:0]                   rdata,
  output logic [N_CH-1:0]                    empty,
  output logic [N_CH-1:0]                    aempty,
  output logic [N_CH-1:0]                    full,
  output logic [N_CH*$clog2(DEPTH+1)-1:0]    used_slots,
  input  logic [N_CH-1:0]                    clr,
  output logic [N_CH-1:0]                    overflow,
  output logic [N_CH-1:0]                    underflow
);

  localparam int CW = idx_w(N_CH);
  localparam int UW = $clog2(DEPTH + 1);

  logic [N_CH-1:0]  wr_sel;
  logic [N_CH-1:0]  rd_sel;
  logic [WIDTH-1:0] chan_rdata [N_CH];
  logic [UW-1:0]    chan_used  [N_CH];

  // An out-of-range channel select matches no channel, so the request is
  // dropped without touching any flag.
  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
      assign wr_sel[c] = wr && (wr_ch == CW'(c));
      assign rd_sel[c] = rd && (rd_ch == CW'(c));

      cr_huf_comp_mq_chan #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .AFULL_LVL  (AFULL_LVL),
        .AEMPTY_LVL (AEMPTY_LVL)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr[c]),
        .wr        (wr_sel[c]),
        .wdata     (wdata),
        .rd        (rd_sel[c]),
        .rdata     (chan_rdata[c]),
        .used      (chan_used[c]),
        .empty     (empty[c]),
        .aempty    (aempty[c]),
        .full      (full[c]),
        .rdy       (rdy[c]),
        .overflow  (overflow[c]),
        .underflow (underflow[c])
      );

      assign used_slots[c*UW +: UW] = chan_used[c];
    end
  endgenerate

  always_comb begin
    rdata = chan_rdata[0];
    for (int c = 1; c < N_CH; c++) begin
      if (rd_ch == CW'(c)) rdata = chan_rdata[c];
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_mq.sv
// tb/tb_cr_huf_comp_mq.sv - self-checking bench for cr_huf_comp_mq
module tb_cr_huf_comp_mq;

  localparam int N_CH  = 2;
  localparam int DEPTH = 8;
  localparam int WIDTH = 75;
  localparam int AFULL = 6;
  localparam int UW    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr;
  logic [0:0]        wr_ch;
  logic [WIDTH-1:0]  wdata;
  logic [N_CH-1:0]   rdy;
  logic              rd;
  logic [0:0]        rd_ch;
  logic [WIDTH-1:0]  rdata;
  logic [N_CH-1:0]   empty, aempty, full;
  logic [N_CH*UW-1:0] used_slots;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one queue of entries per channel plus sticky flags.
  logic [WIDTH-1:0] mq [N_CH][$];
  logic             m_ovf [N_CH];
  logic             m_unf [N_CH];
  bit               mdl_ok = 0;

  always #5 clk = ~clk;

  cr_huf_comp_mq #(
    .N_CH(N_CH), .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_LVL(AFULL), .AEMPTY_LVL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wr_ch(wr_ch), .wdata(wdata), .rdy(rdy),
    .rd(rd), .rd_ch(rd_ch), .rdata(rdata), .empty(empty), .aempty(aempty),
    .full(full), .used_slots(used_slots), .clr(clr), .overflow(overflow),
    .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    for (int c = 0; c < N_CH; c++) begin
      int sz;
      sz = mq[c].size();
      chk($sformatf("used%0d", c),  128'(used_slots[c*UW +: UW]), 128'(sz));
      chk($sformatf("empty%0d", c), 128'(empty[c]),  128'(sz == 0));
      chk($sformatf("full%0d", c),  128'(full[c]),   128'(sz == DEPTH));
      chk($sformatf("aempty%0d", c),128'(aempty[c]), 128'(sz == 1));
      chk($sformatf("ovf%0d", c),   128'(overflow[c]),  128'(m_ovf[c]));
      chk($sformatf("unf%0d", c),   128'(underflow[c]), 128'(m_unf[c]));
    end
  endtask

  // One clock: drive, check combinational outputs mid-cycle, clock, update
  // the model, check registered status.
  task automatic step(input logic i_rst_n, input logic i_wr, input logic i_wr_ch,
                      input logic [WIDTH-1:0] i_wdata, input logic i_rd,
                      input logic i_rd_ch, input logic [N_CH-1:0] i_clr);
    rst_n = i_rst_n; wr = i_wr; wr_ch = i_wr_ch; wdata = i_wdata;
    rd = i_rd; rd_ch = i_rd_ch; clr = i_clr;
    #3;
    if (mdl_ok) begin
      for (int c = 0; c < N_CH; c++) begin
        int sz;
        bit exp_rdy;
        sz = mq[c].size();
        exp_rdy = (sz < AFULL) || (sz != DEPTH && !(i_wr && int'(i_wr_ch) == c));
        chk($sformatf("rdy%0d", c), 128'(rdy[c]), 128'(exp_rdy));
      end
      if (mq[i_rd_ch].size() != 0)
        chk($sformatf("rdata_ch%0d", i_rd_ch), 128'(rdata), 128'(mq[i_rd_ch][0]));
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) begin
      if (!i_rst_n || i_clr[c]) begin
        mq[c].delete();
        m_ovf[c] = 1'b0;
        m_unf[c] = 1'b0;
      end else begin
        bit was_full, was_empty;
        was_full  = (mq[c].size() == DEPTH);
        was_empty = (mq[c].size() == 0);
        if (i_rd && int'(i_rd_ch) == c) begin
          if (was_empty) m_unf[c] = 1'b1;
          else void'(mq[c].pop_front());
        end
        if (i_wr && int'(i_wr_ch) == c) begin
          if (was_full) m_ovf[c] = 1'b1;
          else mq[c].push_back(i_wdata);
        end
      end
    end
    if (!i_rst_n) mdl_ok = 1;
    if (mdl_ok) check_status();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_data();
    return WIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    rst_n = 1'b1; wr = 1'b0; wr_ch = '0; wdata = '0; rd = 1'b0; rd_ch = '0; clr = '0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    idle();
    chk("post_reset_empty", 128'(empty), 128'(2'b11));
    chk("post_reset_used",  128'(used_slots), 128'(0));

    // Fill ch0 with 1..8; ready guard engages at 6 while writing
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0, '0);
    chk("fill_full0", 128'(full[0]), 128'(1));
    chk("fill_used0", 128'(used_slots[3:0]), 128'(8));
    chk("fill_empty1", 128'(empty[1]), 128'(1));
    idle();
    chk("fill_head0", 128'(rdata), 128'(1));

    // Write + pop on full ch0: write dropped, oldest popped
    step(1'b1, 1'b1, 1'b0, WIDTH'(99), 1'b1, 1'b0, '0);
    chk("ovf_used0", 128'(used_slots[3:0]), 128'(7));
    chk("ovf_flag0", 128'(overflow[0]), 128'(1));
    idle();
    chk("ovf_head0", 128'(rdata), 128'(2));

    // Ch1: 4 deep, 12 simultaneous wr/rd pairs wrap the pointers
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, WIDTH'(16 + i), 1'b0, 1'b1, '0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, WIDTH'(32 + i), 1'b1, 1'b1, '0);
    chk("wrap_used1", 128'(used_slots[7:4]), 128'(4));

    // Drain ch1, pop empty, then flush clears the sticky flag
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, '0);
    chk("unf_flag1", 128'(underflow[1]), 128'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b10);
    chk("clr_unf1", 128'(underflow[1]), 128'(0));

    // Reset mid-operation with a write pending
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, rnd_data(), 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, rnd_data(), 1'b0, 1'b0, '0);
    chk("rst_used0", 128'(used_slots[3:0]), 128'(0));
    chk("rst_empty0", 128'(empty[0]), 128'(1));
    idle();

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      logic          r_rst_n;
      logic [1:0]    r_clr;
      r_rst_n = ($urandom_range(0, 299) != 0);
      r_clr[0] = ($urandom_range(0, 59) == 0);
      r_clr[1] = ($urandom_range(0, 59) == 0);
      step(r_rst_n, ($urandom_range(0, 99) < 60), 1'($urandom()), rnd_data(),
           ($urandom_range(0, 99) < 50), 1'($urandom()), r_clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
